// File: rtl/uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions and the transmit FSM state encoding.
package uart_tx_pkg;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_CTRL    = 4'h8;
  localparam logic [3:0] OFF_BAUDDIV = 4'hC;

  localparam int STATUS_BUSY  = 0;
  localparam int STATUS_FULL  = 1;
  localparam int STATUS_EMPTY = 2;
  localparam int STATUS_OVF   = 3;
  localparam int STATUS_FILL  = 4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_OVF_CLR = 1;
  localparam int CTRL_IE      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter. A push while full is
// accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus. Optional
// interrupt output and CTRL.ie bit are built when UART_TX_IRQ_EN is defined.
module mmio_uart_tx
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        tx
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state;
  logic          en;
  logic          ovf;
  logic          ie;
  logic [15:0]   baud_div;
  logic [15:0]   div_eff;
  logic [15:0]   reload;
  logic [15:0]   cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          busy;
  logic          in_win;
  logic          wr_txdata;
  logic          wr_ctrl;
  logic          wr_baud;
  logic          fifo_pop;
  logic          unused_bits;

  assign in_win    = (A[31:4] == BASE_ADDR[31:4]);
  assign wr_txdata = WE && in_win && (A[3:2] == OFF_TXDATA[3:2]);
  assign wr_ctrl   = WE && in_win && (A[3:2] == OFF_CTRL[3:2]);
  assign wr_baud   = WE && in_win && (A[3:2] == OFF_BAUDDIV[3:2]);
  assign busy      = (state != ST_IDLE);
  assign fifo_pop  = (state == ST_IDLE) && en && !empty;
  assign div_eff   = (baud_div == 16'd0) ? 16'd1 : baud_div;
  assign unused_bits = &{1'b0, A[1:0], WD[31:16]};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_txdata),
    .din   (WD[7:0]),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Control registers; an overflowing push beats a same-cycle ovf clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en       <= 1'b0;
      ovf      <= 1'b0;
      ie       <= 1'b0;
      baud_div <= DIV_RESET;
    end else begin
      if (wr_ctrl) begin
        en <= WD[CTRL_EN];
`ifdef UART_TX_IRQ_EN
        ie <= WD[CTRL_IE];
`endif
      end
      if (wr_baud) baud_div <= WD[15:0];
      if (wr_txdata && full && !fifo_pop) ovf <= 1'b1;
      else if (wr_ctrl && WD[CTRL_OVF_CLR]) ovf <= 1'b0;
    end
  end

  // Bit period counts down from reload-1; the divider is latched per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      shreg   <= 8'd0;
      reload  <= 16'd1;
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
          if (fifo_pop) begin
            shreg  <= head;
            reload <= div_eff;
            cnt    <= div_eff - 16'd1;
            tx     <= 1'b0;
            state  <= ST_START;
          end
        end
        ST_START: begin
          if (cnt == 16'd0) begin
            cnt     <= reload - 16'd1;
            bit_idx <= 3'd0;
            tx      <= shreg[0];
            state   <= ST_DATA;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (cnt == 16'd0) begin
            cnt <= reload - 16'd1;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (cnt == 16'd0) state <= ST_IDLE;
          else              cnt   <= cnt - 16'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_TX_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= ie && empty && !busy;
  end
`endif

  always_comb begin
    RD = 32'd0;
    if (in_win) begin
      case (A[3:2])
        OFF_STATUS[3:2]: begin
          RD[STATUS_BUSY]  = busy;
          RD[STATUS_FULL]  = full;
          RD[STATUS_EMPTY] = empty;
          RD[STATUS_OVF]   = ovf;
          RD[STATUS_FILL +: 4] = 4'(count);
        end
        OFF_CTRL[3:2]: begin
          RD[CTRL_EN] = en;
          RD[CTRL_IE] = ie;
        end
        OFF_BAUDDIV[3:2]: RD[15:0] = baud_div;
        default: RD = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register reset values, frame timing,
// overflow, back-to-back frames, mid-frame changes, reset and address decode.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE    = 32'h0000_1000;
  localparam logic [31:0] TXDATA  = BASE + 32'h0;
  localparam logic [31:0] STATUS  = BASE + 32'h4;
  localparam logic [31:0] CTRL    = BASE + 32'h8;
  localparam logic [31:0] BAUDDIV = BASE + 32'hC;

  logic        clk;
  logic        rst_n;
  logic        WE;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        tx;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(4), .DIV_RESET(16'd434)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .WE    (WE),
    .A     (A),
    .WD    (WD),
    .RD    (RD),
    .tx    (tx)
`ifdef UART_TX_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bus write committed on the next rising edge; returns 1 time unit after it.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    WE = 1'b1; A = addr; WD = data;
    @(posedge clk);
    #1;
    WE = 1'b0; A = 32'd0; WD = 32'd0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    A = addr;
    #1;
    chk(tag, RD, exp);
    A = 32'd0;
  endtask

  // Called 1 time unit after the pop edge; returns in the following idle cycle.
  task automatic check_frame(input logic [7:0] b, input int div, input bit chk_busy,
                             input string tag);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < div; c++) begin
        if (chk_busy) begin
          A = STATUS;
          #1;
          chk({tag, "_busy"}, {31'd0, RD[0]}, 32'd1);
        end
        chk($sformatf("%s_bit%0d_c%0d", tag, k, c), {31'd0, tx}, {31'd0, fr[k]});
        @(posedge clk);
        #1;
      end
    end
  endtask

  logic [7:0] ob [4];

  initial begin
    ob = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst_n = 1'b0; WE = 1'b0; A = 32'd0; WD = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    rd_chk("rst_status_in_reset", STATUS, 32'h4);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd_chk("reset_status", STATUS, 32'h4);
    rd_chk("reset_ctrl", CTRL, 32'h0);
    rd_chk("reset_baud", BAUDDIV, 32'd434);
    rd_chk("reset_txdata_reads0", TXDATA, 32'h0);

    // Single frame, divider 4, one-cycle latency from write to start bit.
    wr(BAUDDIV, 32'd4);
    wr(CTRL, 32'h1);
    wr(TXDATA, 32'h55);
    chk("f55_latency", {31'd0, tx}, 32'd1);
    @(posedge clk);
    #1;
    check_frame(8'h55, 4, 1'b1, "f55");
    rd_chk("f55_status_after", STATUS, 32'h4);

    // Overflow with en=0, then drain four frames at divider 0 (acts as 1).
    wr(CTRL, 32'h0);
    wr(BAUDDIV, 32'd0);
    wr(TXDATA, 32'h11);
    wr(TXDATA, 32'h22);
    wr(TXDATA, 32'h33);
    wr(TXDATA, 32'h44);
    wr(TXDATA, 32'h99);
    rd_chk("ovf_status", STATUS, 32'h4A);
    rd_chk("ovf_baud0", BAUDDIV, 32'h0);
    wr(CTRL, 32'h2);
    rd_chk("ovf_clr_ctrl", CTRL, 32'h0);
    rd_chk("ovf_clr_status", STATUS, 32'h42);
    chk("ovf_held_tx", {31'd0, tx}, 32'd1);
    wr(CTRL, 32'h1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check_frame(ob[i], 1, 1'b0, $sformatf("ovf_f%0d", i));
      chk($sformatf("ovf_gap%0d", i), {31'd0, tx}, 32'd1);
      if (i < 3) begin
        @(posedge clk);
        #1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("ovf_no_fifth", {31'd0, tx}, 32'd1);
    end
    rd_chk("ovf_drained", STATUS, 32'h4);

    // Back-to-back frames; divider change in frame 1, en cleared in frame 2.
    wr(CTRL, 32'h0);
    wr(TXDATA, 32'hA3);
    wr(TXDATA, 32'h0F);
    wr(TXDATA, 32'h3C);
    wr(BAUDDIV, 32'd2);
    wr(CTRL, 32'h1);
    @(posedge clk);
    #1;
    fork
      check_frame(8'hA3, 2, 1'b0, "fa3");
      begin
        repeat (5) @(posedge clk);
        wr(BAUDDIV, 32'd3);
      end
    join
    chk("b2b_gap", {31'd0, tx}, 32'd1);
    @(posedge clk);
    #1;
    fork
      check_frame(8'h0F, 3, 1'b0, "f0f");
      begin
        repeat (4) @(posedge clk);
        wr(CTRL, 32'h0);
      end
    join
    for (int i = 0; i < 6; i++) begin
      chk("en_off_idle", {31'd0, tx}, 32'd1);
      @(posedge clk);
      #1;
    end
    rd_chk("en_off_status", STATUS, 32'h10);
    rd_chk("baud_now3", BAUDDIV, 32'd3);

    // Reset in the middle of the first data bit (0x3C bit0 = 0).
    wr(TXDATA, 32'h77);
    wr(BAUDDIV, 32'd4);
    wr(CTRL, 32'h1);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_tx", {31'd0, tx}, 32'd0);
    rd_chk("pre_rst_status", STATUS, 32'h11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_tx", {31'd0, tx}, 32'd1);
    rd_chk("rst_async_status", STATUS, 32'h4);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd_chk("post_rst_ctrl", CTRL, 32'h0);
    rd_chk("post_rst_baud", BAUDDIV, 32'd434);
    rd_chk("post_rst_status", STATUS, 32'h4);

    // Address decode: nothing outside the window or at read-only offsets.
    wr(CTRL, 32'h1);
    wr(BASE + 32'h10, 32'hAB);
    wr(32'h0, 32'hCD);
    wr(STATUS, 32'hFF);
    wr(32'h0000_200C, 32'h5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("dec_tx_idle", {31'd0, tx}, 32'd1);
    end
    rd_chk("dec_status", STATUS, 32'h4);
    rd_chk("dec_rd_outside", BASE + 32'h10, 32'h0);
    rd_chk("dec_rd_zero", 32'h0, 32'h0);
    rd_chk("dec_baud", BAUDDIV, 32'd434);
    rd_chk("dec_ctrl", CTRL, 32'h1);
    rd_chk("dec_alias_bits10", BASE + 32'hB, 32'h1);

`ifdef UART_TX_IRQ_EN
    wr(BAUDDIV, 32'd1);
    wr(CTRL, 32'h5);
    rd_chk("irq_ctrl", CTRL, 32'h5);
    @(posedge clk);
    #1;
    chk("irq_idle", {31'd0, irq}, 32'd1);
    wr(TXDATA, 32'h5A);
    @(posedge clk);
    #1;
    chk("irq_busy_start", {31'd0, irq}, 32'd0);
    check_frame(8'h5A, 1, 1'b0, "f5a");
    chk("irq_stop_end", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    chk("irq_rise", {31'd0, irq}, 32'd1);
    wr(TXDATA, 32'h00);
    @(posedge clk);
    #1;
    chk("irq_drop", {31'd0, irq}, 32'd0);
`else
    wr(CTRL, 32'h5);
    rd_chk("ctrl_ie_absent", CTRL, 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter. It is a responder on the CPU data-memory bus (same WE/A/WD/RD handshake as the data memory), sitting beside dmem behind the address decode.
- CPU stores enqueue bytes into a small FIFO. A bit-serial FSM shifts them out as 8N1 frames on `tx`.
- Loads return status/control registers combinationally, matching the single-cycle core's read timing.

Parameters:
- BASE_ADDR, 32'h0000_1000: register window base; window is 16 bytes (A[31:4] == BASE_ADDR[31:4]).
- FIFO_DEPTH, 4: TX FIFO entries; power of two, ≥2.
- DIV_RESET, 16'd434: reset value of BAUDDIV (50 MHz / 115200).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- WE  in  1  write enable; store commits on rising clk edge
- A  in  32  byte address from core
- WD  in  32  store data
- RD  out  32  read data, combinational from A and register state
- tx  out  1  serial output, idles high

Behaviour:
- Register map (offset from BASE_ADDR; A[1:0] ignored):
  - 0x0 TXDATA (W): a write pushes WD[7:0]. Reads 0.
  - 0x4 STATUS (R): bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 ovf (sticky), bits[7:4] fill count. Writes ignored.
  - 0x8 CTRL (R/W): bit0 en. Writing bit1=1 clears ovf; bit1 reads 0.
  - 0xC BAUDDIV (R/W): bits[15:0], cycles per bit. Value 0 is treated as 1.
- Address decode:
  - Any other address in the window, or any address outside it: RD = 0, writes ignored.
  - WE with A outside the window has no effect.
- Reset (asynchronous): tx=1; FIFO empty; FSM IDLE; en=0; ovf=0; BAUDDIV=DIV_RESET. RD therefore reflects reset state immediately.
- FIFO:
  - A push while full is dropped and sets ovf.
  - Exception: a push while full in the same cycle as an FSM pop is accepted.
  - Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if en && !empty, pop the head into an 8-bit shift register, latch BAUDDIV into the bit-period reload, go to START. tx=1.
  - START: tx=0 for one bit period, then DATA.
  - DATA: 8 bits, LSB first, one bit period each, bit counter 0..7; after bit 7 go to STOP.
  - STOP: tx=1 for one bit period, then IDLE.
  - Back-to-back: IDLE may pop on the cycle after STOP ends, so the gap between frames is 1 cycle.
- Latency: a TXDATA write at edge N with FSM IDLE and en=1 → pop at edge N+1 → tx low from edge N+1.
- Frame length: 10·BAUDDIV cycles.
- Boundary conditions:
  - Clearing en mid-frame: the current frame completes; no new pop.
  - Writing BAUDDIV mid-frame: affects the next frame only.
  - Writing TXDATA with en=0: the byte queues and is held until en=1.
  - Reset mid-frame: tx returns high immediately; queued bytes are lost.
  - Simultaneous ovf clear and overflowing push: ovf ends set (set wins).

Optional Feature:
- Macro: UART_TX_IRQ_EN.
- Defined:
  - Adds output `irq` (1 bit, reset 0).
  - CTRL bit2 = ie (R/W, reset 0).
  - irq = ie && empty && !busy, registered, one-cycle latency.
- Undefined: no `irq` port; CTRL bit2 reads 0 and writes are ignored.

Decomposition:
- Package uart_tx_pkg:
  - register offset constants (TXDATA/STATUS/CTRL/BAUDDIV);
  - STATUS and CTRL bit-position constants;
  - FSM state encoding (2-bit typedef).
- Sub-module: uart_tx_fifo, a synchronous FIFO with push/pop/full/empty/count, parameterised by depth and width 8. Top holds the decode, registers and FSM.

Test Plan:
- Reset values: after rst_n low→high, read 0x4 → 0x00000004 (empty); read 0x8 → 0; read 0xC → 434; tx=1.
- Single frame: BAUDDIV=4, en=1, write 0x55 → tx sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles, starting 1 cycle after the write. busy=1 for 40 cycles, then STATUS → 0x04.
- Overflow: en=0, write 5 bytes with FIFO_DEPTH=4 → STATUS = 0x4A (count 4, full, ovf). Write CTRL=0x2 → ovf clears, CTRL reads 0. Set en → 4 frames, the 5th byte is absent.
- Back-to-back and mid-frame changes: queue 0xA3, 0x0F with BAUDDIV=2. Change BAUDDIV to 3 during frame 1 → frame 1 bits are 2 cycles and frame 2 bits are 3 cycles. Exactly 1 idle-high cycle between frames.
- Reset and decode: assert rst_n mid-DATA → tx=1 asynchronously and FIFO empty. Write to BASE_ADDR+0x10 and to 0x0 → no state change, RD=0.
- IRQ (UART_TX_IRQ_EN): ie=1, send one byte → irq=0 while busy; irq rises 1 cycle after STOP ends; a write to TXDATA drops irq.
